// File: rtl/fpu_seq.sv
// FPU phase sequencer: decodes FP/long-arithmetic instructions into the F-PM phase lines
// f2..f13 and the strob_fp_/strob2_fp strobes, and reacts to F-PM status and fault lines.
module fpu_seq #(
    parameter int unsigned F8_MAX    = 40,
    parameter int unsigned MUL_STEPS = 40,
    parameter int unsigned MW_STEPS  = 16,
    parameter int unsigned NORM_MAX  = 40
) (
    input  logic       __clk,
    input  logic       _0_f,
    input  logic       start,
    input  logic       pufa,
    input  logic [7:9] ir,
    input  logic       nrf,
    input  logic       fic,
    input  logic       nz,
    input  logic       fi0_,
    input  logic       fi1_,
    input  logic       fi2_,
    input  logic       fi3_,
    output logic       f2_,
    output logic       f4_,
    output logic       f5_,
    output logic       f6_,
    output logic       f7_,
    output logic       f8_,
    output logic       f10_,
    output logic       f9,
    output logic       f13,
    output logic       strob_fp_,
    output logic       strob2_fp,
    output logic       busy,
    output logic       done,
    output logic [0:3] fault
);

    typedef enum logic [3:0] {
        StIdle, StF2, StF4, StF5, StF6, StF7, StF8, StF9, StF10, StF13
    } state_e;

    // Encodings 0..7 follow the ir field directly when pufa=1.
    typedef enum logic [3:0] {
        OpAd, OpSd, OpMw, OpDw, OpAf, OpSf, OpMf, OpDf, OpNrf, OpConv
    } op_e;

    state_e     state_q, state_d, next_ph;
    op_e        op_q, op_d, op_dec;
    logic [1:0] cyc_q, cyc_d;
    logic [5:0] pass_q, pass_d, pass_sat;
    logic [6:0] passes;
    logic [0:3] fault_q, fault_d, fi_low;
    logic       done_q, done_d;
    logic       f8_again;

    assign fi_low   = ~{fi0_, fi1_, fi2_, fi3_};
    assign pass_sat = (&pass_q) ? pass_q : pass_q + 6'd1;
    // Passes completed once the current one ends.
    assign passes   = {1'b0, pass_q} + 7'd1;

    always_comb begin
        op_dec = OpNrf;
        if (pufa) begin
            op_dec = op_e'({1'b0, ir});
        end else if (ir[7]) begin
            op_dec = OpConv;
        end
    end

    always_comb begin
        f8_again = 1'b0;
        if (op_q == OpAf || op_q == OpSf) begin
            f8_again = fic && (32'(passes) < F8_MAX);
        end else if (op_q == OpMw || op_q == OpDw) begin
            f8_again = 32'(passes) < MW_STEPS;
        end else begin
            f8_again = 32'(passes) < MUL_STEPS;
        end
    end

    always_comb begin
        next_ph = StIdle;
        unique case (state_q)
            StF2: begin
                if (op_q == OpConv)     next_ph = StF13;
                else if (op_q == OpNrf) next_ph = StF6;
                else                    next_ph = StF4;
            end
            StF4: begin
                if (op_q == OpAd || op_q == OpSd)      next_ph = StF7;
                else if (op_q == OpAf || op_q == OpSf) next_ph = StF5;
                else                                   next_ph = StF8;
            end
            StF5: next_ph = StF8;
            StF8: begin
                if (f8_again)                          next_ph = StF8;
                else if (op_q == OpMw)                 next_ph = StF10;
                else if (op_q == OpDw || op_q == OpDf) next_ph = StF9;
                else                                   next_ph = StF6;
            end
            StF9:  next_ph = (op_q == OpDw) ? StF10 : StF6;
            StF6:  next_ph = (nz && (32'(passes) < NORM_MAX)) ? StF6 : StF7;
            StF7:  next_ph = (op_q == OpAd || op_q == OpSd) ? StIdle : StF10;
            StF13: next_ph = StF10;
            default: next_ph = StIdle;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        fault_d = fault_q;
        done_d  = 1'b0;
        if (state_q == StIdle) begin
            if (start && (pufa || nrf)) begin
                op_d    = op_dec;
                fault_d = '0;
                cyc_d   = '0;
                pass_d  = '0;
                state_d = (op_dec == OpAd || op_dec == OpSd) ? StF4 : StF2;
            end
        end else if (cyc_q != 2'd0 && fi_low != '0) begin
            // Fault during strobe cycles aborts the whole sequence.
            fault_d = fault_q | fi_low;
            state_d = StIdle;
            cyc_d   = '0;
            pass_d  = '0;
            done_d  = 1'b1;
        end else if (cyc_q == 2'd2) begin
            state_d = next_ph;
            cyc_d   = '0;
            pass_d  = (next_ph == state_q) ? pass_sat : '0;
            done_d  = (next_ph == StIdle);
        end else begin
            cyc_d = cyc_q + 2'd1;
        end
    end

    always_ff @(posedge __clk) begin
        if (_0_f) begin
            state_q <= StIdle;
            op_q    <= OpAd;
            cyc_q   <= '0;
            pass_q  <= '0;
            fault_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign f2_       = (state_q != StF2);
    assign f4_       = (state_q != StF4);
    assign f5_       = (state_q != StF5);
    assign f6_       = (state_q != StF6);
    assign f7_       = (state_q != StF7);
    assign f8_       = (state_q != StF8);
    assign f10_      = (state_q != StF10);
    assign f9        = (state_q == StF9);
    assign f13       = (state_q == StF13);
    assign strob_fp_ = !(busy && cyc_q == 2'd1);
    assign strob2_fp = busy && (cyc_q == 2'd2);
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: procedural phase-list reference model compared every cycle,
// directed scenarios with literal latencies, then randomized traffic.
module tb_fpu_seq;

    localparam int F8_MAX    = 40;
    localparam int MUL_STEPS = 40;
    localparam int MW_STEPS  = 16;
    localparam int NORM_MAX  = 40;

    logic       __clk = 1'b0;
    logic       _0_f, start, pufa, nrf, fic, nz, fi0_, fi1_, fi2_, fi3_;
    logic [7:9] ir;
    logic       f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp_, strob2_fp, busy, done;
    logic [0:3] fault;

    fpu_seq dut (
        .__clk(__clk), ._0_f(_0_f), .start(start), .pufa(pufa), .ir(ir), .nrf(nrf),
        .fic(fic), .nz(nz), .fi0_(fi0_), .fi1_(fi1_), .fi2_(fi2_), .fi3_(fi3_),
        .f2_(f2_), .f4_(f4_), .f5_(f5_), .f6_(f6_), .f7_(f7_), .f8_(f8_), .f10_(f10_),
        .f9(f9), .f13(f13), .strob_fp_(strob_fp_), .strob2_fp(strob2_fp), .busy(busy),
        .done(done), .fault(fault)
    );

    always #5 __clk = ~__clk;

    int checks = 0;
    int errors = 0;

    // Model expectations for the current cycle: active phase number (0 = none), cycle 1..3.
    int         exp_ph  = 0;
    int         exp_cyc = 0;
    logic       exp_done = 1'b0;
    logic [0:3] fault_m = '0;
    bit         chk_en = 1'b0;
    int         m_res;   // 0 running, 1 fault abort, 2 reset abort
    bit         m_smp;   // loop condition sampled in cycle 3
    logic [12:0] exp_v, act_v;

    task automatic phase(input int ph);
        if (m_res != 0) return;
        for (int c = 1; c <= 3; c++) begin
            exp_ph   = ph;
            exp_cyc  = c;
            exp_done = 1'b0;
            @(posedge __clk);
            if (_0_f) begin
                m_res = 2;
                return;
            end
            if (c >= 2 && {fi0_, fi1_, fi2_, fi3_} != 4'hf) begin
                fault_m = fault_m | ~{fi0_, fi1_, fi2_, fi3_};
                m_res   = 1;
                return;
            end
            if (c == 3) m_smp = (ph == 8) ? fic : nz;
        end
    endtask

    // op: 0 AD,1 SD,2 MW,3 DW,4 AF,5 SF,6 MF,7 DF,8 NRF,9 CONV
    task automatic run_op(input int op);
        int n;
        m_res = 0;
        if (op <= 1) begin
            phase(4);
            phase(7);
            return;
        end
        phase(2);
        if (op == 9) begin
            phase(13);
            phase(10);
            return;
        end
        if (op != 8) begin
            phase(4);
            if (op == 4 || op == 5) begin
                phase(5);
                n = 0;
                m_smp = 1'b1;
                while (m_res == 0 && m_smp && n < F8_MAX) begin
                    phase(8);
                    n++;
                end
            end else begin
                repeat ((op == 2 || op == 3) ? MW_STEPS : MUL_STEPS) phase(8);
                if (op == 3 || op == 7) phase(9);
                if (op == 2 || op == 3) begin
                    phase(10);
                    return;
                end
            end
        end
        n = 0;
        m_smp = 1'b1;
        while (m_res == 0 && m_smp && n < NORM_MAX) begin
            phase(6);
            n++;
        end
        phase(7);
        phase(10);
    endtask

    initial begin : model
        int op;
        bit done_next;
        done_next = 1'b0;
        forever begin
            exp_ph   = 0;
            exp_cyc  = 0;
            exp_done = done_next;
            @(posedge __clk);
            done_next = 1'b0;
            if (_0_f) begin
                fault_m = '0;
            end else if (start && (pufa || nrf)) begin
                fault_m = '0;
                if (pufa) op = int'({ir[7], ir[8], ir[9]});
                else      op = ir[7] ? 9 : 8;
                run_op(op);
                if (m_res == 2) fault_m = '0;
                else            done_next = 1'b1;
            end
        end
    end

    always @(negedge __clk) begin
        if (chk_en) begin
            exp_v = {exp_ph != 2, exp_ph != 4, exp_ph != 5, exp_ph != 6, exp_ph != 7,
                     exp_ph != 8, exp_ph != 10, exp_ph == 9, exp_ph == 13,
                     !(exp_ph != 0 && exp_cyc == 2), exp_ph != 0 && exp_cyc == 3,
                     exp_ph != 0, exp_done};
            act_v = {f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp_, strob2_fp,
                     busy, done};
            checks++;
            if (act_v !== exp_v || fault !== fault_m) begin
                errors++;
                $display("FAIL cycle t=%0t: outputs %b fault %b, required %b fault %b",
                         $time, act_v, fault, exp_v, fault_m);
            end
        end
    end

    task automatic directed(input string name, input logic pf, input logic nr,
                            input logic [2:0] op3, input int fic_until, input logic nz_v,
                            input int flt_k, input int rst_k, input int restart_k,
                            input int lim, input int exp_lat, input int exp_strb,
                            input logic [0:3] exp_flt, input int exp_f6);
        int lat, strb, f6c;
        logic [0:3] flt_at_done;
        lat = -1;
        strb = 0;
        f6c = 0;
        flt_at_done = '0;
        @(posedge __clk); #1;
        pufa = pf; nrf = nr; ir = op3; start = 1'b1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge __clk); #1;
            start = (k == restart_k);
            fic   = (k <= fic_until);
            nz    = nz_v;
            {fi0_, fi1_, fi2_, fi3_} = (k == flt_k) ? 4'b1110 : 4'b1111;
            _0_f  = (k == rst_k);
            @(negedge __clk);
            if (!strob_fp_) strb++;
            if (!f6_) f6c++;
            if (done) begin
                lat = k;
                flt_at_done = fault;
                break;
            end
        end
        _0_f = 1'b0;
        start = 1'b0;
        {fi0_, fi1_, fi2_, fi3_} = 4'b1111;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        if (exp_strb >= 0) begin
            checks++;
            if (strb != exp_strb) begin
                errors++;
                $display("FAIL %s strobes: got %0d, required %0d", name, strb, exp_strb);
            end
        end
        if (exp_f6 >= 0) begin
            checks++;
            if (f6c != 3 * exp_f6) begin
                errors++;
                $display("FAIL %s f6 cycles: got %0d, required %0d", name, f6c, 3 * exp_f6);
            end
        end
        if (lat > 0) begin
            checks++;
            if (flt_at_done !== exp_flt) begin
                errors++;
                $display("FAIL %s fault: got %b, required %b", name, flt_at_done, exp_flt);
            end
        end
    endtask

    initial begin
        _0_f = 1'b1; start = 1'b0; pufa = 1'b0; nrf = 1'b0; ir = 3'b000;
        fic = 1'b0; nz = 1'b0; {fi0_, fi1_, fi2_, fi3_} = 4'b1111;
        repeat (2) @(posedge __clk);
        #1 _0_f = 1'b0;
        @(negedge __clk);
        checks++;
        if ({f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp_, strob2_fp, busy, done,
             fault} !== 17'b1111111_00_10_00_0000) begin
            errors++;
            $display("FAIL reset: outputs %b%b%b%b%b%b%b %b%b %b%b %b%b fault %b, required reset values",
                     f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp_, strob2_fp,
                     busy, done, fault);
        end
        chk_en = 1'b1;

        directed("MW",       1, 0, 3'b010, 0,    0, 0, 0,  0, 100, 58,  19, 4'b0000, -1);
        directed("DW",       1, 0, 3'b011, 0,    0, 0, 0,  0, 100, 61,  20, 4'b0000, -1);
        directed("AF",       1, 0, 3'b100, 15,   0, 0, 0,  0, 100, 28,  9,  4'b0000, 1);
        directed("AD",       1, 0, 3'b000, 0,    0, 0, 0,  3, 100, 7,   2,  4'b0000, 0);
        directed("SF_fault", 1, 0, 3'b101, 0,    0, 5, 0,  0, 100, 6,   2,  4'b0001, -1);
        directed("AD_clr",   1, 0, 3'b000, 0,    0, 0, 0,  0, 100, 7,   2,  4'b0000, -1);
        directed("MF_nz",    1, 0, 3'b110, 0,    1, 0, 0,  0, 400, 253, 84, 4'b0000, 40);
        directed("MF_rst",   1, 0, 3'b110, 0,    0, 0, 20, 0, 30,  -1,  -1, 4'b0000, -1);
        directed("AF_cap",   1, 0, 3'b100, 1000, 0, 0, 0,  0, 300, 139, 46, 4'b0000, 1);
        directed("CONV",     0, 1, 3'b100, 0,    0, 0, 0,  0, 100, 10,  3,  4'b0000, -1);
        directed("NRF",      0, 1, 3'b000, 0,    0, 0, 0,  0, 100, 13,  4,  4'b0000, 1);
        directed("ignored",  0, 0, 3'b110, 0,    0, 0, 0,  0, 10,  -1,  0,  4'b0000, -1);

        for (int i = 0; i < 8000; i++) begin
            @(posedge __clk); #1;
            start = ($urandom_range(0, 3) == 0);
            pufa  = ($urandom_range(0, 3) != 0);
            nrf   = 1'($urandom);
            ir    = 3'($urandom);
            fic   = ($urandom_range(0, 2) != 0);
            nz    = ($urandom_range(0, 2) == 0);
            fi0_  = ($urandom_range(0, 1999) != 0);
            fi1_  = ($urandom_range(0, 1999) != 0);
            fi2_  = ($urandom_range(0, 1999) != 0);
            fi3_  = ($urandom_range(0, 1999) != 0);
            _0_f  = ($urandom_range(0, 999) == 0);
        end
        @(posedge __clk); #1;
        start = 1'b0; _0_f = 1'b0; {fi0_, fi1_, fi2_, fi3_} = 4'b1111;
        repeat (300) @(posedge __clk);
        @(negedge __clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
